dice_roller_n: RTL and testbench
================================

Name: dice_roller_n

Overview:
- Parametrised successor to the single-d20 roller.
- Rolls NUM_DICE dice of SIDES faces each and sums them.
- Runs a timed "rolling" animation on a two-digit active-low seven-segment display, then latches and shows the total.
- Sits between a debounced push-button and the board's two seven-segment digits. It also exposes binary results for downstream game logic.

Parameters:
- SIDES, 20, faces per die; legal 2..99.
- NUM_DICE, 1, dice summed; legal 1..4; SIDES*NUM_DICE must be ≤ 99 (elaboration error otherwise).
- ROLL_CYCLES, 32, clock cycles spent in ROLLING before latching; legal ≥ 1.
- ANIM_DIV, 4, display refresh divider during ROLLING: the display takes the live sum every ANIM_DIV cycles; legal ≥ 1.
- BLANK_LZ, 1, 1 = blank the tens digit when the total is < 10; 0 = show a leading 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- roll  in  1  roll request, asynchronous to clk; level-sensitive button.
- seg_tens  out  7  tens digit, bit order {g,f,e,d,c,b,a}, active-low.
- seg_ones  out  7  ones digit, same encoding.
- total  out  SUM_W  latched sum; 0 means no roll yet. SUM_W = $clog2(SIDES*NUM_DICE+1).
- die_vals  out  NUM_DICE*DIE_W  latched per-die values, die 0 in the LSBs. DIE_W = $clog2(SIDES+1).
- busy  out  1  high while in ROLLING.
- done  out  1  one-cycle pulse on the cycle the result latches.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE; all die counters = 1; total = 0; die_vals = 0; busy = 0; done = 0.
  - Synchroniser flops = 0; both digits show dash (7'h3F).
- Input sync: roll passes through 2 flops (s1, s2), then an edge flop s3. rise = s2 & ~s3. A held button produces exactly one rise.
- Die counters:
  - Free-running odometer, advancing every clock in every state.
  - Die 0 steps 1..SIDES and wraps SIDES -> 1.
  - Die k (k > 0) advances only on the cycle all lower dice wrap simultaneously.
  - The full all-SIDES -> all-1 wrap happens in a single cycle.
- live_sum = combinational sum of the counters, SUM_W wide; it never overflows by parameter constraint.
- FSM states: IDLE, ROLLING, SHOW.
  - IDLE: on rise -> ROLLING; roll_cnt := 0; anim_cnt := 0.
  - ROLLING:
    - busy = 1; roll_cnt increments each cycle.
    - On anim_cnt == ANIM_DIV-1: display register := live_sum and anim_cnt := 0.
    - When roll_cnt == ROLL_CYCLES-1: on that edge, total := live_sum and die_vals := counters. Display register := live_sum. done pulses high the following cycle. State -> SHOW.
    - rise during ROLLING is ignored and not queued.
  - SHOW: display holds total. rise -> ROLLING, a re-roll with identical timing.
- Latency: roll's rising edge at the pins to busy high is 4 clk edges (3 sync/edge flops + FSM register). busy high to done pulse is ROLL_CYCLES cycles.
- Display encode, registered value v in 0..99:
  - ones = v mod 10; tens = v / 10.
  - Digit codes 0..9 = 40,79,24,30,19,12,02,78,00,18 (hex).
  - Tens blank (7'h7F) when BLANK_LZ=1 and v < 10.
  - In IDLE after reset, both digits show dash 7'h3F.
- Reset mid-ROLLING: immediate return to reset values, no done pulse. The display returns to dashes.

Decomposition:
- Shared package dice_pkg holds:
  - The state enum.
  - The SEG_DIGIT[0:9] constant array, SEG_BLANK, SEG_DASH.
  - Width helper functions.
- One sub-module, dice_seg7_2digit: combinational v (7 bits) + blank_lz + show_dash -> seg_tens, seg_ones. It is reused by the scoreboard display.

Test Plan:
- Reset with SIDES=20, NUM_DICE=1: digits = 3F/3F, total = 0, busy = 0; release reset, hold 50 cycles -> no change, counter observed wrapping 20 -> 1.
- SIDES=6, NUM_DICE=2, ROLL_CYCLES=8: press roll once -> busy for exactly 8 cycles, single done pulse, total equals the model sum (2..12), die_vals each in 1..6.
- Odometer boundary SIDES=6, NUM_DICE=2: from counters (6,6), one clock -> (1,1); force the latch on that cycle -> total = 2, digits 7F/24 (BLANK_LZ=1).
- Encode check SIDES=99, NUM_DICE=1: totals 7, 10, 99 -> 7F/78, 79/40, 18/18; with BLANK_LZ=0, 7 -> 40/78.
- Button held 100 cycles, plus extra presses during ROLLING -> exactly one roll and one done pulse; press in SHOW -> new roll with the same 4-cycle entry latency.
- Assert reset at ROLLING cycle 3 -> all outputs at reset values asynchronously, no done pulse; the next roll behaves normally.

Source files
------------

// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared FSM states, seven-segment codes and width helpers for dice_roller_n
// Contents: state_e (IDLE/ROLLING/SHOW), SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH,
//           die_width(sides), sum_width(sides, num_dice).
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SHOW    = 2'd2
  } state_e;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic int die_width(input int sides);
    return $clog2(sides + 1);
  endfunction

  function automatic int sum_width(input int sides, input int num_dice);
    return $clog2(sides * num_dice + 1);
  endfunction

endpackage

// File: rtl/dice_seg7_2digit.sv
// rtl/dice_seg7_2digit.sv - combinational 0..99 to two active-low seven-segment digits
// Ports: v_i         value to show (0..99)
//        blank_lz_i  blank the tens digit when v_i < 10
//        show_dash_i force both digits to a dash
//        seg_tens_o  tens digit {g,f,e,d,c,b,a}, active-low
//        seg_ones_o  ones digit, same encoding
module dice_seg7_2digit
  import dice_pkg::*;
(
  input  logic [6:0] v_i,
  input  logic       blank_lz_i,
  input  logic       show_dash_i,
  output logic [6:0] seg_tens_o,
  output logic [6:0] seg_ones_o
);

  logic [6:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens       = v_i / 7'd10;
    ones       = 4'(v_i % 7'd10);
    seg_tens_o = SEG_DASH;
    seg_ones_o = SEG_DASH;
    // Values above 99 cannot occur by parameter limits; they fall back to dashes.
    if (!show_dash_i && tens < 7'd10) begin
      seg_ones_o = SEG_DIGIT[ones];
      seg_tens_o = (blank_lz_i && tens == 7'd0) ? SEG_BLANK : SEG_DIGIT[tens[3:0]];
    end
  end

endmodule

// File: rtl/dice_roller_n.sv
// rtl/dice_roller_n.sv - NUM_DICE x SIDES dice roller with animated two-digit display
// Ports: clk       system clock
//        reset     asynchronous active-high reset
//        roll      button level, asynchronous to clk
//        seg_tens  tens digit, active-low {g,f,e,d,c,b,a}
//        seg_ones  ones digit, active-low
//        total     latched sum, 0 until the first roll completes
//        die_vals  latched per-die values, die 0 in the LSBs
//        busy      high while rolling
//        done      one-cycle pulse after the result latches
module dice_roller_n
  import dice_pkg::*;
#(
  parameter int SIDES       = 20,
  parameter int NUM_DICE    = 1,
  parameter int ROLL_CYCLES = 32,
  parameter int ANIM_DIV    = 4,
  parameter bit BLANK_LZ    = 1'b1,
  localparam int DIE_W      = die_width(SIDES),
  localparam int SUM_W      = sum_width(SIDES, NUM_DICE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      roll,
  output logic [6:0]                seg_tens,
  output logic [6:0]                seg_ones,
  output logic [SUM_W-1:0]          total,
  output logic [NUM_DICE*DIE_W-1:0] die_vals,
  output logic                      busy,
  output logic                      done
);

  if (SIDES < 2 || SIDES > 99 || NUM_DICE < 1 || NUM_DICE > 4 ||
      SIDES * NUM_DICE > 99 || ROLL_CYCLES < 1 || ANIM_DIV < 1) begin : g_param_check
    $error("dice_roller_n: illegal parameter combination");
  end

  localparam int RC_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam int AN_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [RC_W-1:0] ROLL_LAST = RC_W'(ROLL_CYCLES - 1);
  localparam logic [AN_W-1:0] ANIM_LAST = AN_W'(ANIM_DIV - 1);

  // Button synchroniser and rising-edge detect. The rise pulse is registered
  // so the FSM only ever sees a flop output.
  logic s1_q, s2_q, s3_q, rise_q;

  // Odometer of die counters.
  logic [NUM_DICE-1:0][DIE_W-1:0] die_q, die_d;
  logic                           carry;
  logic [SUM_W-1:0]               live_sum;

  state_e                    state_q, state_d;
  logic [RC_W-1:0]           roll_cnt_q, roll_cnt_d;
  logic [AN_W-1:0]           anim_cnt_q, anim_cnt_d;
  logic [SUM_W-1:0]          total_q, total_d;
  logic [NUM_DICE*DIE_W-1:0] die_vals_q, die_vals_d;
  logic [6:0]                disp_q, disp_d;
  logic                      done_q, done_d;

  // A die advances only when every lower die is wrapping on this cycle, so
  // the all-SIDES state rolls over to all-ones in one clock.
  always_comb begin
    die_d = die_q;
    carry = 1'b1;
    for (int k = 0; k < NUM_DICE; k++) begin
      if (carry) begin
        die_d[k] = (die_q[k] == DIE_W'(SIDES)) ? DIE_W'(1) : die_q[k] + DIE_W'(1);
      end
      carry = carry & (die_q[k] == DIE_W'(SIDES));
    end
  end

  always_comb begin
    live_sum = '0;
    for (int k = 0; k < NUM_DICE; k++) begin
      live_sum = live_sum + SUM_W'(die_q[k]);
    end
  end

  always_comb begin
    state_d    = state_q;
    roll_cnt_d = roll_cnt_q;
    anim_cnt_d = anim_cnt_q;
    total_d    = total_q;
    die_vals_d = die_vals_q;
    disp_d     = disp_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, SHOW: begin
        if (rise_q) begin
          state_d    = ROLLING;
          roll_cnt_d = '0;
          anim_cnt_d = '0;
        end
      end
      ROLLING: begin
        // Presses arriving here are dropped, not queued.
        roll_cnt_d = roll_cnt_q + RC_W'(1);
        anim_cnt_d = anim_cnt_q + AN_W'(1);
        if (anim_cnt_q == ANIM_LAST) begin
          disp_d     = 7'(live_sum);
          anim_cnt_d = '0;
        end
        if (roll_cnt_q == ROLL_LAST) begin
          total_d    = live_sum;
          die_vals_d = die_q;
          disp_d     = 7'(live_sum);
          done_d     = 1'b1;
          state_d    = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      rise_q     <= 1'b0;
      for (int k = 0; k < NUM_DICE; k++) begin
        die_q[k] <= DIE_W'(1);
      end
      state_q    <= IDLE;
      roll_cnt_q <= '0;
      anim_cnt_q <= '0;
      total_q    <= '0;
      die_vals_q <= '0;
      disp_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      s1_q       <= roll;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      rise_q     <= s2_q & ~s3_q;
      die_q      <= die_d;
      state_q    <= state_d;
      roll_cnt_q <= roll_cnt_d;
      anim_cnt_q <= anim_cnt_d;
      total_q    <= total_d;
      die_vals_q <= die_vals_d;
      disp_q     <= disp_d;
      done_q     <= done_d;
    end
  end

  // IDLE is only reachable through reset, so it doubles as "no roll yet".
  dice_seg7_2digit u_seg (
    .v_i         (disp_q),
    .blank_lz_i  (BLANK_LZ),
    .show_dash_i (state_q == IDLE),
    .seg_tens_o  (seg_tens),
    .seg_ones_o  (seg_ones)
  );

  assign total    = total_q;
  assign die_vals = die_vals_q;
  assign busy     = (state_q == ROLLING);
  assign done     = done_q;

endmodule

// File: tb/tb_dice_roller_n.sv
// tb/tb_dice_roller_n.sv - scoreboard bench for dice_roller_n (6x2 roller and two d99 encoders)
module tb_dice_roller_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: two d6, 8-cycle roll.
  logic       rst_a = 1'b1, roll_a = 1'b0;
  logic [6:0] st_a, so_a;
  logic [3:0] total_a;
  logic [5:0] dv_a;
  logic       busy_a, done_a;

  // Instances B/C: one d99, 4-cycle roll, leading zero blanked (B) or shown (C).
  logic       rst_b = 1'b1, roll_b = 1'b0;
  logic [6:0] st_b, so_b, st_c, so_c;
  logic [6:0] total_b, total_c, dv_b, dv_c;
  logic       busy_b, done_b, busy_c, done_c;

  dice_roller_n #(.SIDES(6), .NUM_DICE(2), .ROLL_CYCLES(8), .ANIM_DIV(4), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .reset(rst_a), .roll(roll_a), .seg_tens(st_a), .seg_ones(so_a),
    .total(total_a), .die_vals(dv_a), .busy(busy_a), .done(done_a));

  dice_roller_n #(.SIDES(99), .NUM_DICE(1), .ROLL_CYCLES(4), .ANIM_DIV(2), .BLANK_LZ(1'b1)) u_b (
    .clk(clk), .reset(rst_b), .roll(roll_b), .seg_tens(st_b), .seg_ones(so_b),
    .total(total_b), .die_vals(dv_b), .busy(busy_b), .done(done_b));

  dice_roller_n #(.SIDES(99), .NUM_DICE(1), .ROLL_CYCLES(4), .ANIM_DIV(2), .BLANK_LZ(1'b0)) u_c (
    .clk(clk), .reset(rst_b), .roll(roll_b), .seg_tens(st_c), .seg_ones(so_c),
    .total(total_c), .die_vals(dv_c), .busy(busy_c), .done(done_c));

  localparam logic [6:0] DIG [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Clock edges since reset release; the die counters step once per edge.
  int ecnt_a = 0, ecnt_b = 0;
  always @(posedge clk or posedge rst_a) if (rst_a) ecnt_a <= 0; else ecnt_a <= ecnt_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) ecnt_b <= 0; else ecnt_b <= ecnt_b + 1;

  // Two-d6 odometer state after m edges.
  function automatic int d0_of(input int m); return (m % 6) + 1; endfunction
  function automatic int d1_of(input int m); return ((m / 6) % 6) + 1; endfunction

  // Expected {tens, ones} with the leading zero blanked.
  function automatic logic [13:0] seg_of(input int v);
    logic [6:0] t;
    t = (v < 10) ? 7'h7F : DIG[v / 10];
    return {t, DIG[v % 10]};
  endfunction

  typedef struct { int total; int dvals; logic [6:0] st; logic [6:0] so; } exp_a_t;
  typedef struct { int total; logic [6:0] bt; logic [6:0] bo; logic [6:0] ct; logic [6:0] co; } exp_b_t;
  exp_a_t qa[$];
  exp_b_t qb[$];
  int n_push_a = 0;
  int done_cnt_a = 0;
  int busy_run_a = 0;

  // Monitor A: pops on every done pulse, also checks the busy window length.
  always @(negedge clk) begin
    exp_a_t e;
    if (rst_a) busy_run_a = 0;
    else begin
      if (busy_a) busy_run_a++;
      if (done_a) begin
        done_cnt_a++;
        if (qa.size() == 0) chk("a_unexpected_done", 0, 1);
        else begin
          e = qa.pop_front();
          chk("a_total", total_a, e.total);
          chk("a_die_vals", dv_a, e.dvals);
          chk("a_seg_tens", st_a, e.st);
          chk("a_seg_ones", so_a, e.so);
          chk("a_busy_cycles", busy_run_a, 8);
        end
        busy_run_a = 0;
      end
    end
  end

  // Monitor B/C: both instances share stimulus, so they latch the same value.
  always @(negedge clk) begin
    exp_b_t e;
    if (!rst_b && done_b) begin
      if (qb.size() == 0) chk("b_unexpected_done", 0, 1);
      else begin
        e = qb.pop_front();
        chk("b_total", total_b, e.total);
        chk("b_die_vals", dv_b, e.total);
        chk("b_seg_tens", st_b, e.bt);
        chk("b_seg_ones", so_b, e.bo);
        chk("c_done", done_c, 1);
        chk("c_total", total_c, e.total);
        chk("c_seg_tens", st_c, e.ct);
        chk("c_seg_ones", so_c, e.co);
      end
    end
  end

  // Press A (at a chosen odometer phase when mod36 >= 0), push the expected
  // result, check the 4-edge entry latency and the first animation refresh.
  task automatic press_a(input int mod36, input bit glitch);
    int lim, lat, m, ma, v;
    exp_a_t e;
    lim = 0;
    if (mod36 >= 0)
      while (((ecnt_a + 11) % 36) != mod36 && lim < 100) begin @(negedge clk); lim++; end
    m = ecnt_a + 11;   // latch edge is press + 4 + 8; counters seen after m edges
    ma = ecnt_a + 7;   // first display refresh, 4 edges into ROLLING
    e.total = d0_of(m) + d1_of(m);
    e.dvals = d1_of(m) * 8 + d0_of(m);
    {e.st, e.so} = seg_of(e.total);
    qa.push_back(e);
    n_push_a++;
    roll_a = 1'b1;
    lat = 0;
    while (!busy_a && lat < 20) begin @(negedge clk); lat++; end
    chk("a_entry_latency", lat, 4);
    if (glitch) roll_a = 1'b0;
    @(negedge clk);
    if (glitch) roll_a = 1'b1;
    repeat (3) @(negedge clk);
    v = d0_of(ma) + d1_of(ma);
    chk("a_anim_display", {st_a, so_a}, seg_of(v));
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (!done_a && n < 60) begin @(negedge clk); n++; end
    if (!done_a) chk("a_done_timeout", 0, 1);
  endtask

  task automatic press_b(input int target, input logic [13:0] sb, input logic [13:0] sc);
    int lim, lat;
    exp_b_t e;
    lim = 0;
    while ((((ecnt_b + 7) % 99) + 1) != target && lim < 120) begin @(negedge clk); lim++; end
    e.total = target;
    {e.bt, e.bo} = sb;
    {e.ct, e.co} = sc;
    qb.push_back(e);
    roll_b = 1'b1;
    lat = 0;
    while (!busy_b && lat < 20) begin @(negedge clk); lat++; end
    chk("b_entry_latency", lat, 4);
    lat = 0;
    while (!done_b && lat < 30) begin @(negedge clk); lat++; end
    if (!done_b) chk("b_done_timeout", 0, 1);
    roll_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_seg_tens"}, st_a, 7'h3F);
    chk({tag, "_seg_ones"}, so_a, 7'h3F);
    chk({tag, "_total"}, total_a, 0);
    chk({tag, "_die_vals"}, dv_a, 0);
    chk({tag, "_busy_done"}, {busy_a, done_a}, 0);
  endtask

  initial begin
    int bad, dc;
    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_a("a_reset");
    chk("b_reset_segs", {st_b, so_b}, 14'h1FBF);
    rst_a = 1'b0;

    // Idle with no press: nothing changes.
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (st_a !== 7'h3F || so_a !== 7'h3F || total_a !== 4'd0 || busy_a || done_a) bad++;
    end
    chk("a_idle_hold", bad, 0);

    // Plain roll.
    press_a(-1, 1'b0);
    wait_done_a();
    roll_a = 1'b0;
    repeat (4) @(negedge clk);

    // Latch on the (6,6)->(1,1) wrap cycle, then on (6,6).
    press_a(0, 1'b0);
    wait_done_a();
    @(negedge clk);
    chk("a_wrap_total", total_a, 2);
    chk("a_wrap_segs", {st_a, so_a}, {7'h7F, 7'h24});
    roll_a = 1'b0;
    repeat (4) @(negedge clk);
    press_a(35, 1'b0);
    wait_done_a();
    roll_a = 1'b0;
    repeat (4) @(negedge clk);

    // Held button with an extra press inside ROLLING: one roll only.
    press_a(-1, 1'b1);
    wait_done_a();
    bad = 0;
    repeat (90) begin @(negedge clk); if (busy_a) bad++; end
    chk("a_held_no_reroll", bad, 0);
    roll_a = 1'b0;
    repeat (4) @(negedge clk);

    // Re-roll from SHOW.
    press_a(-1, 1'b0);
    wait_done_a();
    roll_a = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during ROLLING cycle 3.
    dc = done_cnt_a;
    roll_a = 1'b1;
    bad = 0;
    while (!busy_a && bad < 20) begin @(negedge clk); bad++; end
    repeat (3) @(negedge clk);
    #1 rst_a = 1'b1;
    #1 check_reset_a("a_midroll_reset");
    roll_a = 1'b0;
    repeat (12) @(negedge clk);
    chk("a_no_done_after_reset", done_cnt_a, dc);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    press_a(-1, 1'b0);
    wait_done_a();
    roll_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("a_done_count", done_cnt_a, n_push_a);
    chk("a_queue_empty", qa.size(), 0);

    // Encoder vectors on the d99 pair.
    rst_b = 1'b0;
    @(negedge clk);
    press_b(7,  {7'h7F, 7'h78}, {7'h40, 7'h78});
    press_b(99, {7'h18, 7'h18}, {7'h18, 7'h18});
    press_b(10, {7'h79, 7'h40}, {7'h79, 7'h40});
    chk("b_queue_empty", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
